// File: rtl/intc_ctrl.sv
// Prioritised interrupt controller on the word-addressed device bus (MASK/PENDING/STATUS/EOI).
// Define INTC_LEVEL_EN for level mode (PENDING follows src_irq_i); default build latches rising edges.
module intc_ctrl #(
  parameter int NSRC = 6,
  parameter int ID_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      addr_i,
  input  logic            we_i,
  input  logic [31:0]     data_in_i,
  output logic [31:0]     data_out_o,
  input  logic [NSRC-1:0] src_irq_i,
  input  logic            cpu_ack_i,
  output logic            cpu_irq_o,
  output logic [ID_W-1:0] irq_id_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SERV = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic            cpu_irq_q, cpu_irq_d;
  logic [ID_W-1:0] irq_id_q, irq_id_d;

  logic [NSRC-1:0] pending_s;
  logic [NSRC-1:0] eligible_s;
  logic [NSRC-1:0] cur_oh_s;
  logic [NSRC-1:0] ack_clr_s;
  logic [ID_W-1:0] winner_s;
  logic [31:0]     rdata_s;
  logic            wr_mask_s, wr_pend_s, wr_eoi_s;
  logic            unused_s;

  assign wr_mask_s = we_i && (addr_i == 2'b00);
  assign wr_pend_s = we_i && (addr_i == 2'b01);
  assign wr_eoi_s  = we_i && (addr_i == 2'b11);

`ifdef INTC_LEVEL_EN
  assign pending_s = src_irq_i;
  assign unused_s  = ^{data_in_i, ack_clr_s, wr_pend_s};
`else
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] w1c_clr_s;

  assign w1c_clr_s = wr_pend_s ? data_in_i[NSRC-1:0] : {NSRC{1'b0}};
  // A rise in the same cycle as a W1C or ack clear wins, so no edge is lost.
  assign pending_d = (pending_q & ~(w1c_clr_s | ack_clr_s)) | (src_irq_i & ~src_q);
  assign pending_s = pending_q;
  assign unused_s  = ^data_in_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= {NSRC{1'b0}};
      pending_q <= {NSRC{1'b0}};
    end else begin
      src_q     <= src_irq_i;
      pending_q <= pending_d;
    end
  end
`endif

  assign mask_d     = wr_mask_s ? data_in_i[NSRC-1:0] : mask_q;
  assign eligible_s = pending_s & mask_q;

  always_comb begin
    winner_s = {ID_W{1'b0}};
    cur_oh_s = {NSRC{1'b0}};
    for (int i = NSRC - 1; i >= 0; i--) begin
      winner_s = eligible_s[i] ? ID_W'(i) : winner_s;
    end
    for (int i = 0; i < NSRC; i++) begin
      cur_oh_s[i] = (cur_id_q == ID_W'(i));
    end
  end

  // cur_id stays frozen through REQ and SERV: no preemption by a higher-priority arrival.
  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    cpu_irq_d = cpu_irq_q;
    ack_clr_s = {NSRC{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (|eligible_s) begin
          state_d   = ST_REQ;
          cur_id_d  = winner_s;
          cpu_irq_d = 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (cpu_ack_i) begin
          ack_clr_s = cur_oh_s;
          cpu_irq_d = 1'b0;
          state_d   = ST_SERV;
        end else if (!(|(cur_oh_s & mask_q & pending_s))) begin
          cpu_irq_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d   = ST_REQ;
        end
      end
      ST_SERV: begin
        if (wr_eoi_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERV;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cpu_irq_d = 1'b0;
      end
    endcase
  end

  assign irq_id_d = (state_d != ST_IDLE) ? cur_id_d : {ID_W{1'b0}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mask_q    <= {NSRC{1'b0}};
      cur_id_q  <= {ID_W{1'b0}};
      cpu_irq_q <= 1'b0;
      irq_id_q  <= {ID_W{1'b0}};
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cur_id_q  <= cur_id_d;
      cpu_irq_q <= cpu_irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  always_comb begin
    rdata_s = 32'h0000_0000;
    case (addr_i)
      2'b00: rdata_s[NSRC-1:0] = mask_q;
      2'b01: rdata_s[NSRC-1:0] = pending_s;
      2'b10: begin
        rdata_s[ID_W-1:0] = cur_id_q;
        rdata_s[9:8]      = state_q;
        rdata_s[16]       = cpu_irq_q;
      end
      default: rdata_s = 32'h0000_0000;
    endcase
  end

  assign data_out_o = rdata_s;
  assign cpu_irq_o  = cpu_irq_q;
  assign irq_id_o   = irq_id_q;

endmodule
